// File: rtl/gd_audio_pkg.sv
// rtl/gd_audio_pkg.sv - shared types and address constants for the audio write scheduler
package gd_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Audio write-address regions: page in addr[14:11], voice block in addr[10:8]
  localparam logic [3:0]  AUD_PAGE      = 4'h5;
  localparam logic [2:0]  AUD_VOICE_BLK = 3'b010;
  localparam logic [10:0] AUD_MODVOICE  = 11'h014;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } gd_audio_wr_t;

endpackage

// File: rtl/gd_audio_update_sched_if.sv
// rtl/gd_audio_update_sched_if.sv - host command queue port (push + commit handshake)
interface gd_audio_update_sched_if;
  import gd_audio_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_commit;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_commit,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_commit,
    output cmd_ready
  );

endinterface

// File: rtl/gd_sched_fifo.sv
// rtl/gd_sched_fifo.sv - DEPTH x 23-bit queue with write/read/commit pointers.
// GD_SCHED_COALESCE_EN: a push matching the newest uncommitted address rewrites its data.
module gd_sched_fifo
  import gd_audio_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  gd_audio_wr_t wdata,
  input  logic         pop,
  input  logic         commit,
  output gd_audio_wr_t rdata,
  output logic [AW:0]  rd_ptr,
  output logic [AW:0]  commit_ptr,
  output logic [AW:0]  count,
  output logic [AW:0]  committed_next,
  output logic         full
);

  gd_audio_wr_t ram_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic        push;
  logic        ovr;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));

`ifdef GD_SCHED_COALESCE_EN
  logic [AW-1:0] newest_idx;
  assign newest_idx = wr_ptr_q[AW-1:0] - AW'(1);
  // Allowed while full: it rewrites an existing slot instead of allocating one
  assign ovr = wr_req && (wr_ptr_q != commit_ptr_q) && (ram_q[newest_idx].addr == wdata.addr);
`else
  assign ovr = 1'b0;
`endif

  assign push = wr_req && !full && !ovr;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ram_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
`ifdef GD_SCHED_COALESCE_EN
    else if (ovr) begin
      ram_q[newest_idx] <= wdata;
    end
`endif
  end

  assign rdata          = ram_q[rd_ptr_q[AW-1:0]];
  assign rd_ptr         = rd_ptr_q;
  assign commit_ptr     = commit_ptr_q;
  assign committed_next = commit_ptr_d - rd_ptr_d;

endmodule

// File: rtl/gd_audio_update_sched.sv
// rtl/gd_audio_update_sched.sv - frame-synchronous batch scheduler for audio voice writes,
// arbitrated against direct host writes. Optional GD_SCHED_COALESCE_EN (see gd_sched_fifo).
module gd_audio_update_sched
  import gd_audio_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int MAX_PER_FRAME = 32
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  gd_audio_update_sched_if.slave        cmd,
  input  logic                          cpu_wr,
  input  logic [14:0]                   cpu_addr,
  input  logic [7:0]                    cpu_data,
  output logic                          mem_wr,
  output logic [14:0]                   mem_w_addr,
  output logic [7:0]                    mem_data_wr,
  output logic [6:0]                    pending,
  output logic                          busy
);

  localparam int AW = $clog2(DEPTH);

  sched_state_e state_q, state_d;
  logic [AW:0]  drain_end_q, drain_end_d;
  logic [5:0]   issue_cnt_q, issue_cnt_d;
  logic         mem_wr_q, mem_wr_d;
  logic [14:0]  mem_addr_q, mem_addr_d;
  logic [7:0]   mem_data_q, mem_data_d;
  logic         busy_q, busy_d;

  gd_audio_wr_t fifo_rdata;
  logic [AW:0]  fifo_rd_ptr;
  logic [AW:0]  fifo_commit_ptr;
  logic [AW:0]  fifo_count;
  logic [AW:0]  fifo_committed_next;
  logic         fifo_full;
  logic         pop;
  logic         last_of_batch;

  gd_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk            (vga_clk),
    .rst            (reset),
    .wr_req         (cmd.cmd_valid),
    .wdata          ({cmd.cmd_addr, cmd.cmd_data}),
    .pop            (pop),
    .commit         (cmd.cmd_commit),
    .rdata          (fifo_rdata),
    .rd_ptr         (fifo_rd_ptr),
    .commit_ptr     (fifo_commit_ptr),
    .count          (fifo_count),
    .committed_next (fifo_committed_next),
    .full           (fifo_full)
  );

  // Host writes win the output register; the scheduled pop simply waits a cycle
  assign pop = (state_q == DRAIN) && !cpu_wr && (fifo_rd_ptr != drain_end_q);
  assign last_of_batch = pop && ((fifo_rd_ptr + (AW+1)'(1) == drain_end_q) ||
                                 (issue_cnt_q + 6'd1 == 6'(MAX_PER_FRAME)));

  always_comb begin
    state_d     = state_q;
    drain_end_d = drain_end_q;
    issue_cnt_d = issue_cnt_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    if (cpu_wr) begin
      mem_wr_d   = 1'b1;
      mem_addr_d = cpu_addr;
      mem_data_d = cpu_data;
    end else if (pop) begin
      mem_wr_d   = 1'b1;
      mem_addr_d = fifo_rdata.addr;
      mem_data_d = fifo_rdata.data;
    end

    case (state_q)
      IDLE: begin
        if (cmd.cmd_commit && (fifo_committed_next != '0)) state_d = ARMED;
      end
      ARMED: begin
        if (frame_tick) begin
          state_d     = DRAIN;
          drain_end_d = fifo_commit_ptr;
          issue_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (pop) issue_cnt_d = issue_cnt_q + 6'd1;
        if (last_of_batch || (fifo_rd_ptr == drain_end_q)) begin
          state_d = (fifo_committed_next != '0) ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_end_q <= '0;
      issue_cnt_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_end_q <= drain_end_d;
      issue_cnt_q <= issue_cnt_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd.cmd_ready = !fifo_full;
  assign mem_wr        = mem_wr_q;
  assign mem_w_addr    = mem_addr_q;
  assign mem_data_wr   = mem_data_q;
  assign pending       = 7'(fifo_count);
  assign busy          = busy_q;

endmodule

// File: tb/tb_gd_audio_update_sched.sv
// tb/tb_gd_audio_update_sched.sv - queue-model bench for gd_audio_update_sched
module tb_gd_audio_update_sched;
  import gd_audio_pkg::*;

  localparam int DEPTH = 16;
  localparam int MAXF  = 5;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        mem_wr;
  logic [14:0] mem_w_addr;
  logic [7:0]  mem_data_wr;
  logic [6:0]  pending;
  logic        busy;

  gd_audio_update_sched_if cmd_if();

  gd_audio_update_sched #(.DEPTH(DEPTH), .MAX_PER_FRAME(MAXF)) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .cmd        (cmd_if),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .mem_wr     (mem_wr),
    .mem_w_addr (mem_w_addr),
    .mem_data_wr(mem_data_wr),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference: a list of queued writes, how many of them are committed, and a drain budget
  typedef struct {
    logic [14:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  int          m_nc = 0;
  int          m_st = 0;
  int          m_left = 0;
  int          m_budget = 0;
  int          m_sz0;
  int          m_nc0;
  bit          m_coal;
  logic        e_wr = 1'b0;
  logic [14:0] e_addr = '0;
  logic [7:0]  e_data = '0;

  always @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_nc = 0; m_st = 0; m_left = 0; m_budget = 0;
      e_wr = 1'b0; e_addr = '0; e_data = '0;
    end else begin
      m_sz0 = mq.size();
      m_nc0 = m_nc;
      e_wr  = 1'b0;
      if (cpu_wr) begin
        e_wr = 1'b1; e_addr = cpu_addr; e_data = cpu_data;
      end else if (m_st == 2) begin
        m_e = mq.pop_front();
        m_nc--; m_left--; m_budget--;
        e_wr = 1'b1; e_addr = m_e.a; e_data = m_e.d;
      end
      m_coal = 1'b0;
`ifdef GD_SCHED_COALESCE_EN
      if (cmd_if.cmd_valid && mq.size() > m_nc && mq[mq.size()-1].a == cmd_if.cmd_addr) begin
        mq[mq.size()-1].d = cmd_if.cmd_data;
        m_coal = 1'b1;
      end
`endif
      if (cmd_if.cmd_valid && !m_coal && m_sz0 < DEPTH) mq.push_back('{cmd_if.cmd_addr, cmd_if.cmd_data});
      if (cmd_if.cmd_commit) m_nc = mq.size();
      if (m_st == 0) begin
        if (cmd_if.cmd_commit && m_nc > 0) m_st = 1;
      end else if (m_st == 1) begin
        if (frame_tick) begin
          m_st = 2; m_left = m_nc0; m_budget = MAXF;
        end
      end else if (m_left == 0 || m_budget == 0) begin
        m_st = (m_nc > 0) ? 1 : 0;
      end
    end
  end

  always @(negedge vga_clk) begin
    if (!reset) begin
      check("mem_wr", int'(mem_wr), int'(e_wr));
      check("mem_w_addr", int'(mem_w_addr), int'(e_addr));
      check("mem_data_wr", int'(mem_data_wr), int'(e_data));
      check("pending", int'(pending), mq.size());
      check("busy", int'(busy), int'(m_st != 0));
      check("cmd_ready", int'(cmd_if.cmd_ready), int'(mq.size() < DEPTH));
    end
  end

  task automatic drive(bit fr, bit cv, logic [14:0] ca, logic [7:0] cd, bit cc,
                       bit cw, logic [14:0] wa, logic [7:0] wd);
    frame_tick        = fr;
    cmd_if.cmd_valid  = cv;
    cmd_if.cmd_addr   = ca;
    cmd_if.cmd_data   = cd;
    cmd_if.cmd_commit = cc;
    cpu_wr            = cw;
    cpu_addr          = wa;
    cpu_data          = wd;
    @(negedge vga_clk);
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic push(logic [14:0] a, logic [7:0] d);
    drive(0, 1, a, d, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_addr = '0; cmd_if.cmd_data = '0; cmd_if.cmd_commit = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("rst_mem_wr", int'(mem_wr), 0);
    check("rst_addr", int'(mem_w_addr), 0);
    check("rst_data", int'(mem_data_wr), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_if.cmd_ready), 1);
    reset = 1'b0;

    // Uncommitted entries never drain
    push(15'h2A10, 8'h01); push(15'h2A11, 8'h02); push(15'h2A12, 8'h03);
    repeat (4) begin
      drive(1, 0, '0, '0, 0, 0, '0, '0);
      check("nocommit_mem_wr", int'(mem_wr), 0);
      idle(2);
    end
    check("nocommit_pending", int'(pending), 3);
    check("nocommit_busy", int'(busy), 0);

    // Two-entry batch lands at T+2 and T+3
    do_reset();
    push(15'h2A00, 8'h11); push(15'h2A02, 8'h22);
    drive(0, 0, '0, '0, 1, 0, '0, '0);
    check("armed_busy", int'(busy), 1);
    drive(1, 0, '0, '0, 0, 0, '0, '0);
    check("t1_mem_wr", int'(mem_wr), 0);
    idle(1);
    check("t2_mem_wr", int'(mem_wr), 1);
    check("t2_addr", int'(mem_w_addr), 'h2A00);
    check("t2_data", int'(mem_data_wr), 'h11);
    idle(1);
    check("t3_mem_wr", int'(mem_wr), 1);
    check("t3_addr", int'(mem_w_addr), 'h2A02);
    check("t3_data", int'(mem_data_wr), 'h22);
    check("t3_pending", int'(pending), 0);
    check("t3_busy", int'(busy), 0);
    idle(1);
    check("t4_mem_wr", int'(mem_wr), 0);
    check("t4_addr_hold", int'(mem_w_addr), 'h2A02);

    // Host write in drain cycle 2 goes first and shifts the batch
    do_reset();
    push(15'h2A00, 8'hA0); push(15'h2A01, 8'hA1); push(15'h2A02, 8'hA2);
    drive(0, 0, '0, '0, 1, 0, '0, '0);
    drive(1, 0, '0, '0, 0, 0, '0, '0);
    idle(1);
    check("arb_e0", int'(mem_w_addr), 'h2A00);
    drive(0, 0, '0, '0, 0, 1, 15'h2814, 8'h05);
    check("arb_cpu_addr", int'(mem_w_addr), 'h2814);
    check("arb_cpu_data", int'(mem_data_wr), 'h05);
    idle(1);
    check("arb_e1", int'(mem_data_wr), 'hA1);
    idle(1);
    check("arb_e2_wr", int'(mem_wr), 1);
    check("arb_e2", int'(mem_data_wr), 'hA2);
    check("arb_busy", int'(busy), 0);

    // Full queue and per-frame issue limit
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(15'h2A00 + 15'(i), 8'(i));
    check("full_ready", int'(cmd_if.cmd_ready), 0);
    check("full_pending", int'(pending), 16);
    push(15'h2B00, 8'hEE);
    check("full_drop_pending", int'(pending), 16);
`ifdef GD_SCHED_COALESCE_EN
    push(15'h2A0F, 8'h7F);
    check("coal_pending", int'(pending), 16);
`endif
    drive(0, 0, '0, '0, 1, 0, '0, '0);
    drive(1, 0, '0, '0, 0, 0, '0, '0);
    idle(6);
    check("frame1_pending", int'(pending), 11);
    check("frame1_busy", int'(busy), 1);
    repeat (3) begin
      drive(1, 0, '0, '0, 0, 0, '0, '0);
      idle(6);
    end
    check("frames_pending", int'(pending), 0);
    check("frames_busy", int'(busy), 0);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 5; i++) push(15'h2A20 + 15'(i), 8'h40 + 8'(i));
    drive(0, 0, '0, '0, 1, 0, '0, '0);
    drive(1, 0, '0, '0, 0, 0, '0, '0);
    idle(2);
    check("mid_mem_wr", int'(mem_wr), 1);
    check("mid_data", int'(mem_data_wr), 'h41);
    #1 reset = 1'b1;
    #1;
    check("async_mem_wr", int'(mem_wr), 0);
    check("async_pending", int'(pending), 0);
    check("async_ready", int'(cmd_if.cmd_ready), 1);
    check("async_busy", int'(busy), 0);
    @(negedge vga_clk);
    reset = 1'b0;
    repeat (3) begin
      drive(1, 0, '0, '0, 0, 0, '0, '0);
      idle(3);
    end
    check("post_rst_mem_wr", int'(mem_wr), 0);
    check("post_rst_pending", int'(pending), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 15) == 0,
            ((i / 500) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0),
            15'h2A00 + 15'($urandom_range(0, 3)), 8'($urandom),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0,
            15'h2800 + 15'($urandom_range(0, 31)), 8'($urandom));
    end
    idle(4);
    repeat (8) begin
      drive(1, 0, '0, '0, 1, 0, '0, '0);
      idle(8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
